shiftrows_iter: RTL and testbench

SHIFTROWS_ITER -- requirements
Module: shiftrows_iter

---
 rtl/shiftrows_iter_if.sv | 29 ++
 rtl/shiftrows_iter.sv | 145 ++++++++++++++
 tb/tb_shiftrows_iter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shiftrows_iter_if.sv
// Block handshake bundle for shiftrows_iter.
//   in_valid/in_ready/inv/state_in : source side, block offered and accepted on in_valid && in_ready
//   out_valid/out_ready/state_out  : sink side, result held until out_ready
//   done_sr                        : one-cycle pulse in the first cycle a result is presented
// The slave modport is the shifter's view; the master modport is the source/sink driver's view.
interface shiftrows_iter_if #(
  parameter int unsigned NB = 4
);
  localparam int unsigned W = 32 * NB;

  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [W-1:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] state_out;
  logic         done_sr;

  modport master (
    output in_valid, inv, state_in, out_ready,
    input  in_ready, out_valid, state_out, done_sr
  );

  modport slave (
    input  in_valid, inv, state_in, out_ready,
    output in_ready, out_valid, state_out, done_sr
  );
endinterface

// File: rtl/shiftrows_iter.sv
// Iterative Rijndael ShiftRows / InvShiftRows, one state row rotated per cycle.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : shiftrows_iter_if.slave (in_valid/in_ready/inv/state_in in,
//          out_valid/out_ready/state_out/done_sr out)
// Byte j of the state sits at state[W-1-8j -: 8] with row j%4, column j/4.
// Rows 1..3 are rotated on the three cycles after accept; the result is
// presented in HOLD until the sink takes it. Row 0 has offset 0 and is never touched.
module shiftrows_iter #(
  parameter int unsigned NB = 4
) (
  input  logic             clk,
  input  logic             rst,
  shiftrows_iter_if.slave  bus
);

  localparam int unsigned W = 32 * NB;

  // Only the Rijndael block sizes with defined row offsets are supported.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shiftrows_iter: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Row rotation offset; NB=8 uses the wider offsets for rows 2 and 3.
  function automatic int unsigned row_offset(input logic [1:0] r);
    int unsigned off;
    case (r)
      2'd0:    off = 0;
      2'd1:    off = 1;
      2'd2:    off = (NB == 8) ? 3 : 2;
      default: off = (NB == 8) ? 4 : 3;
    endcase
    return off;
  endfunction

  // Rotate one row of the state; forward pulls from column c+off, inverse from c-off.
  function automatic logic [W-1:0] rotate_row(input logic [W-1:0] s,
                                              input logic [1:0]   r,
                                              input logic         inv_dir);
    logic [W-1:0] res;
    int unsigned  off;
    int unsigned  rr;
    int unsigned  src;
    res = s;
    rr  = 32'(r);
    off = row_offset(r);
    for (int unsigned c = 0; c < NB; c++) begin
      // Offsets never exceed NB, so one conditional subtract replaces a modulo.
      src = inv_dir ? (c + NB - off) : (c + off);
      if (src >= NB) src = src - NB;
      res[W-1-8*(4*c+rr) -: 8] = s[W-1-8*(4*src+rr) -: 8];
    end
    return res;
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   row_cnt_q, row_cnt_d;
  logic [W-1:0] work_q, work_d;
  logic [W-1:0] state_out_q, state_out_d;
  logic         inv_q, inv_d;
  logic         out_valid_q, out_valid_d;
  logic         done_sr_q, done_sr_d;

  logic         in_ready_c;
  logic         accept_c;
  logic [W-1:0] rot_c;

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    work_d      = work_q;
    inv_d       = inv_q;
    state_out_d = state_out_q;

    in_ready_c = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    accept_c   = bus.in_valid && in_ready_c;
    rot_c      = rotate_row(work_q, row_cnt_q, inv_q);

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        work_d    = rot_c;
        row_cnt_d = row_cnt_q + 2'd1;
        if (row_cnt_q == 2'd3) begin
          state_out_d = rot_c;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept overrides the HOLD exit so handoff and reload share one edge.
    if (accept_c) begin
      work_d    = bus.state_in;
      inv_d     = bus.inv;
      row_cnt_d = 2'd1;
      state_d   = SHIFT;
    end

    out_valid_d = (state_d == HOLD);
    done_sr_d   = (state_q == SHIFT) && (row_cnt_q == 2'd3);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_cnt_q   <= 2'd0;
      work_q      <= '0;
      state_out_q <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_sr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      work_q      <= work_d;
      state_out_q <= state_out_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      done_sr_q   <= done_sr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_out_q;
  assign bus.done_sr   = done_sr_q;

endmodule

// File: tb/tb_shiftrows_iter.sv
// Scoreboard bench for shiftrows_iter: NB=4, 6 and 8 instances side by side.
module tb_shiftrows_iter;

  localparam int unsigned N_INST = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid_a  [N_INST];
  logic         inv_a       [N_INST];
  logic [255:0] sin_a       [N_INST];
  logic         out_ready_a [N_INST];
  logic         in_ready_a  [N_INST];
  logic         out_valid_a [N_INST];
  logic [255:0] sout_a      [N_INST];
  logic         done_a      [N_INST];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NBG = (g == 0) ? 4 : ((g == 1) ? 6 : 8);
    localparam int unsigned WG  = 32 * NBG;
    shiftrows_iter_if #(.NB(NBG)) bus ();
    shiftrows_iter #(.NB(NBG)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.in_valid   = in_valid_a[g];
    assign bus.inv        = inv_a[g];
    assign bus.state_in   = sin_a[g][WG-1:0];
    assign bus.out_ready  = out_ready_a[g];
    assign in_ready_a[g]  = bus.in_ready;
    assign out_valid_a[g] = bus.out_valid;
    assign sout_a[g]      = 256'(bus.state_out);
    assign done_a[g]      = bus.done_sr;
  end

  logic [255:0] exp_q [N_INST][$];
  int unsigned  acc_q [N_INST][$];

  int n_vec = 0;
  int n_err = 0;

  function automatic int nb_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 6 : 8);
  endfunction

  task automatic check(input string name, input int i, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s nb=%0d: got %h want %h", name, nb_of(i), act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int i);
    n_vec++;
    n_err++;
    $display("FAIL %s nb=%0d at cycle %0d", name, nb_of(i), cyc);
  endtask

  // Whole-matrix reference: out(r,c) = in(r,(c +/- Cr) mod NB).
  function automatic logic [255:0] model(input int nb, input logic iv, input logic [255:0] d);
    logic [7:0]   m [4][8];
    logic [255:0] o;
    int w, off, sc;
    w = 32 * nb;
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = d[w-1-8*(4*c+r) -: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        if (r < 2)        off = r;
        else if (nb == 8) off = r + 1;
        else              off = r;
        sc = iv ? ((c - off + nb) % nb) : ((c + off) % nb);
        o[w-1-8*(4*c+r) -: 8] = m[r][sc];
      end
    return o;
  endfunction

  function automatic logic [255:0] rand_state(input int nb);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    if (nb < 8) r = r & ((256'd1 << (32 * nb)) - 256'd1);
    return r;
  endfunction

  // Monitor: result scoreboard, done_sr placement and latency, HOLD stability.
  logic         prev_v [N_INST];
  logic         prev_r [N_INST];
  logic [255:0] prev_o [N_INST];
  logic         mon_rise;
  int unsigned  mon_acc;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        prev_v[i] = 1'b0;
        prev_r[i] = 1'b0;
        prev_o[i] = '0;
      end else begin
        if (in_valid_a[i] && in_ready_a[i]) acc_q[i].push_back(cyc + 1);
        mon_rise = out_valid_a[i] && !prev_v[i];
        if (done_a[i] || mon_rise) begin
          check("done_sr_first_hold", i, 256'(done_a[i]), 256'(mon_rise));
          if (done_a[i]) begin
            if (acc_q[i].size() == 0) fail_now("done_without_accept", i);
            else begin
              mon_acc = acc_q[i].pop_front();
              check("latency", i, 256'(cyc - mon_acc), 256'd3);
            end
          end
        end
        if (out_valid_a[i] && prev_v[i] && !prev_r[i])
          check("state_out_stable", i, sout_a[i], prev_o[i]);
        if (out_valid_a[i] && out_ready_a[i]) begin
          if (exp_q[i].size() == 0) fail_now("unexpected_result", i);
          else check("result", i, sout_a[i], exp_q[i].pop_front());
        end
        prev_v[i] = out_valid_a[i];
        prev_r[i] = out_ready_a[i];
        prev_o[i] = sout_a[i];
      end
    end
  end

  // Offer one block, push its expected result, return the accept cycle.
  task automatic send(input int i, input logic iv, input logic [255:0] d, input logic [255:0] e,
                      input bit keep, output int unsigned acc, output logic handoff);
    in_valid_a[i] = 1'b1;
    inv_a[i]      = iv;
    sin_a[i]      = d;
    exp_q[i].push_back(e);
    acc     = 0;
    handoff = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready_a[i]) begin
        handoff = out_valid_a[i];
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) in_valid_a[i] = 1'b0;
        return;
      end
    end
    fail_now("accept_timeout", i);
    in_valid_a[i] = 1'b0;
  endtask

  task automatic send1(input int i, input logic iv, input logic [255:0] d, input logic [255:0] e);
    int unsigned a;
    logic h;
    send(i, iv, d, e, 1'b0, a, h);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #2;
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) return;
    end
    fail_now("drain_timeout", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [255:0] v4, f4, i4, p6, e6, p8, e8, rv;
  int unsigned  a1, a2, a3;
  logic         h1, h2, h3;

  initial begin
    v4 = 256'h00112233445566778899aabbccddeeff;
    f4 = 256'h0055aaff4499ee3388dd2277cc1166bb;
    i4 = 256'h00ddaa774411eebb885522ffcc996633;
    p6 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    e6 = 256'h00050a0f04090e13080d12170c11160310150207_1401060b;
    p8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    e8 = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      inv_a[i]       = 1'b0;
      sin_a[i]       = '0;
      out_ready_a[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", i, 256'(out_valid_a[i]), 256'd0);
      check("rst_done_sr", i, 256'(done_a[i]), 256'd0);
      check("rst_state_out", i, sout_a[i], 256'd0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("in_ready_after_rst", i, 256'(in_ready_a[i]), 256'd1);

    // NB=4 directed vectors and round trips
    send1(0, 1'b0, v4, f4);
    drain();
    send1(0, 1'b1, v4, i4);
    send1(0, 1'b0, i4, v4);
    send1(0, 1'b1, f4, v4);
    send1(0, 1'b0, 256'hffffffffffffffffffffffffffffffff, 256'hffffffffffffffffffffffffffffffff);
    drain();

    // NB=6 and NB=8: hand vectors, then random forward/inverse round trips
    send1(1, 1'b0, p6, e6);
    send1(1, 1'b1, e6, p6);
    send1(2, 1'b0, p8, e8);
    send1(2, 1'b1, e8, p8);
    for (int k = 0; k < 3; k++) begin
      rv = rand_state(6);
      send1(1, 1'b0, rv, model(6, 1'b0, rv));
      send1(1, 1'b1, model(6, 1'b0, rv), rv);
      send1(1, 1'b1, rv, model(6, 1'b1, rv));
      rv = rand_state(8);
      send1(2, 1'b0, rv, model(8, 1'b0, rv));
      send1(2, 1'b1, model(8, 1'b0, rv), rv);
      send1(2, 1'b1, rv, model(8, 1'b1, rv));
    end
    drain();

    // Sink stalls for several cycles in HOLD
    out_ready_a[0] = 1'b0;
    send1(0, 1'b0, v4, f4);
    h1 = 1'b0;
    for (int n = 0; n < 10 && !h1; n++) begin
      @(negedge clk);
      h1 = out_valid_a[0];
    end
    if (!h1) fail_now("hold_not_reached", 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out_valid", 0, 256'(out_valid_a[0]), 256'd1);
      check("hold_in_ready", 0, 256'(in_ready_a[0]), 256'd0);
    end
    @(posedge clk);
    #1;
    out_ready_a[0] = 1'b1;
    drain();

    // Back-to-back: in_valid held, inputs change during SHIFT
    send(0, 1'b0, v4, f4, 1'b1, a1, h1);
    send(0, 1'b1, v4, i4, 1'b1, a2, h2);
    send(0, 1'b1, f4, v4, 1'b0, a3, h3);
    check("b2b_interval_1", 0, 256'(a2 - a1), 256'd4);
    check("b2b_interval_2", 0, 256'(a3 - a2), 256'd4);
    check("b2b_handoff_1", 0, 256'(h2), 256'd1);
    check("b2b_handoff_2", 0, 256'(h3), 256'd1);
    drain();

    // Reset in SHIFT with row_cnt=2 abandons the block
    send1(0, 1'b0, i4, model(4, 1'b0, i4));
    @(posedge clk);
    #1;
    check("shift_in_ready", 0, 256'(in_ready_a[0]), 256'd0);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 0, 256'(out_valid_a[0]), 256'd0);
    check("async_rst_done_sr", 0, 256'(done_a[0]), 256'd0);
    check("async_rst_state_out", 0, sout_a[0], 256'd0);
    exp_q[0].delete();
    acc_q[0].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst2", 0, 256'(in_ready_a[0]), 256'd1);
    repeat (6) @(posedge clk);
    #1;
    send1(0, 1'b1, v4, i4);
    send1(2, 1'b0, p8, e8);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
